// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - CPU/debug request-grant arbiter for a single-port synchronous RAM
// Optional post-reset RAM clear sweep is compiled in with RAM_CLEAR_ON_RESET_EN.
module ram_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        starve_q;
  logic [1:0]        owner_q;
  logic              run;
  logic              force_dbg;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_last;

`ifdef RAM_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = S_CLEAR;

  logic [ADDR_W-1:0] clr_addr_q;

  // Sweep counter parks on the last address instead of wrapping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_addr_q <= '0;
    end else if (state_q == S_CLEAR && !clr_last) begin
      clr_addr_q <= clr_addr_q + ADDR_W'(1);
    end
  end

  assign clr_addr = clr_addr_q;
  assign clr_last = &clr_addr_q;
`else
  localparam state_t RESET_STATE = S_RUN;

  assign clr_addr = '0;
  assign clr_last = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_last) begin
      state_d = S_RUN;
    end
  end

  // Reset_n gates the grants so nothing reaches the RAM while reset is held.
  always_comb begin
    run       = Reset_n && (state_q == S_RUN);
    force_dbg = (starve_q == WAIT_LIMIT);
    cpu_gnt   = run && cpu_req && !(dbg_req && force_dbg);
    dbg_gnt   = run && dbg_req && (!cpu_req || force_dbg);
    ram_addr  = dbg_gnt ? dbg_addr : cpu_addr;
    ram_data  = dbg_gnt ? dbg_wdata : cpu_wdata;
    ram_wren  = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);
    ram_rden  = (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);
    busy      = 1'b0;
    if (state_q == S_CLEAR) begin
      ram_addr = clr_addr;
      ram_data = '0;
      ram_wren = Reset_n;
      ram_rden = 1'b0;
      busy     = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      starve_q <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      starve_q <= '0;
    end else if (starve_q != WAIT_LIMIT) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  // Owner tag: bit 0 = CPU read in flight, bit 1 = debug read in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      owner_q <= '0;
    end else begin
      owner_q <= {dbg_gnt && !dbg_we, cpu_gnt && !cpu_we};
    end
  end

  assign cpu_rvalid = owner_q[0];
  assign dbg_rvalid = owner_q[1];
  assign cpu_rdata  = ram_q;
  assign dbg_rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - Directed self-checking bench for ram_port_arbiter with a RAM model
module tb_ram_port_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;

`ifdef RAM_CLEAR_ON_RESET_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data, ram_q;
  logic              ram_rden, ram_wren, busy;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  always #5 Clk = ~Clk;

  ram_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_rden  (ram_rden),
    .ram_wren  (ram_wren),
    .ram_q     (ram_q),
    .busy      (busy)
  );

  // Synchronous RAM with one-cycle read latency
  always @(posedge Clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    int  sweep_bad;
    bit  exp_c;
    bit  prev_c;
    bit  prev_d;

    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hA500 ^ 16'(i);

    // Reset with both masters requesting: nothing may be granted
    Reset_n = 1'b0;
    set_cpu(1'b1, 1'b0, 10'h000, 16'h0000);
    set_dbg(1'b1, 1'b0, 10'h000, 16'h0000);
    repeat (3) tick();
    sample();
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_rden", ram_rden, 0);
    check("rst_busy", busy, CLR);

    tick();
    Reset_n = 1'b1;
    set_dbg(1'b0, 1'b0, 10'h000, 16'h0000);

`ifdef RAM_CLEAR_ON_RESET_EN
    sweep_bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      sample();
      if (!(busy === 1'b1 && ram_wren === 1'b1 && ram_rden === 1'b0 &&
            ram_addr === ADDR_W'(i) && ram_data === 16'h0000 &&
            cpu_gnt === 1'b0 && dbg_gnt === 1'b0)) sweep_bad++;
      tick();
    end
    check("sweep_bad_cycles", sweep_bad, 0);
`endif

    // First RUN cycle: held CPU read of address 0 is granted immediately
    sample();
    check("run_busy", busy, 0);
    check("first_cpu_gnt", cpu_gnt, 1);
    check("first_rden", ram_rden, 1);
    check("first_addr", ram_addr, 0);
    tick();
    set_cpu(1'b0, 1'b0, 10'h000, 16'h0000);
    sample();
    check("first_rvalid", cpu_rvalid, 1);
    check("first_rdata", cpu_rdata, CLR ? 16'h0000 : 16'hA500);
    check("first_dbg_rvalid", dbg_rvalid, 0);

    // CPU write then read of 0x005
    tick();
    set_cpu(1'b1, 1'b1, 10'h005, 16'h1234);
    sample();
    check("wr_cpu_gnt", cpu_gnt, 1);
    check("wr_wren", ram_wren, 1);
    check("wr_rden", ram_rden, 0);
    check("wr_addr", ram_addr, 10'h005);
    check("wr_data", ram_data, 16'h1234);
    tick();
    set_cpu(1'b1, 1'b0, 10'h005, 16'h0000);
    sample();
    check("wr_no_rvalid", cpu_rvalid, 0);
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_rden", ram_rden, 1);
    tick();
    set_cpu(1'b0, 1'b0, 10'h007, 16'h5555);
    sample();
    check("rd_rvalid", cpu_rvalid, 1);
    check("rd_rdata", cpu_rdata, 16'h1234);
    check("rd_dbg_rvalid", dbg_rvalid, 0);
    check("idle_wren", ram_wren, 0);
    check("idle_rden", ram_rden, 0);
    check("idle_addr_cpu", ram_addr, 10'h007);
    check("idle_data_cpu", ram_data, 16'h5555);

    // Debug write 0xBEEF at 0x3FF, then CPU reads it back
    tick();
    set_dbg(1'b1, 1'b1, 10'h3FF, 16'hBEEF);
    sample();
    check("dwr_dbg_gnt", dbg_gnt, 1);
    check("dwr_cpu_gnt", cpu_gnt, 0);
    check("dwr_addr", ram_addr, 10'h3FF);
    check("dwr_data", ram_data, 16'hBEEF);
    check("dwr_wren", ram_wren, 1);
    tick();
    set_dbg(1'b0, 1'b0, 10'h000, 16'h0000);
    set_cpu(1'b1, 1'b0, 10'h3FF, 16'h0000);
    sample();
    check("dwr_no_rvalid", dbg_rvalid, 0);
    check("xrd_cpu_gnt", cpu_gnt, 1);
    tick();
    set_cpu(1'b0, 1'b0, 10'h000, 16'h0000);
    sample();
    check("xrd_rvalid", cpu_rvalid, 1);
    check("xrd_rdata", cpu_rdata, 16'hBEEF);

    // Seed addresses 1 and 2
    tick();
    set_cpu(1'b1, 1'b1, 10'h001, 16'h1111);
    tick();
    set_cpu(1'b0, 1'b0, 10'h000, 16'h0000);
    set_dbg(1'b1, 1'b1, 10'h002, 16'h2222);
    tick();
    set_dbg(1'b0, 1'b0, 10'h000, 16'h0000);

    // Alternating reads without contention
    for (int k = 0; k < 4; k++) begin
      tick();
      set_cpu(1'b1, 1'b0, 10'h001, 16'h0000);
      set_dbg(1'b0, 1'b0, 10'h002, 16'h0000);
      sample();
      check("alt_cpu_gnt", cpu_gnt, 1);
      check("alt_cpu_rv_a", cpu_rvalid, 0);
      if (k > 0) begin
        check("alt_dbg_rvalid", dbg_rvalid, 1);
        check("alt_dbg_rdata", dbg_rdata, 16'h2222);
      end
      tick();
      set_cpu(1'b0, 1'b0, 10'h001, 16'h0000);
      set_dbg(1'b1, 1'b0, 10'h002, 16'h0000);
      sample();
      check("alt_dbg_gnt", dbg_gnt, 1);
      check("alt_cpu_rvalid", cpu_rvalid, 1);
      check("alt_cpu_rdata", cpu_rdata, 16'h1111);
      check("alt_dbg_rv_b", dbg_rvalid, 0);
    end
    tick();
    set_dbg(1'b0, 1'b0, 10'h002, 16'h0000);
    sample();
    check("alt_last_dbg_rvalid", dbg_rvalid, 1);
    check("alt_last_dbg_rdata", dbg_rdata, 16'h2222);

    // Contention: both held, expect C,C,C,C,D repeating
    prev_c = 1'b0;
    prev_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      set_cpu(1'b1, 1'b0, 10'h001, 16'h0000);
      set_dbg(1'b1, 1'b0, 10'h002, 16'h0000);
      sample();
      exp_c = (i % 5) != 4;
      check("cont_cpu_gnt", cpu_gnt, exp_c);
      check("cont_dbg_gnt", dbg_gnt, !exp_c);
      check("cont_addr", ram_addr, exp_c ? 10'h001 : 10'h002);
      check("cont_cpu_rvalid", cpu_rvalid, prev_c);
      check("cont_dbg_rvalid", dbg_rvalid, prev_d);
      if (prev_c || prev_d) check("cont_rdata", cpu_rdata, prev_c ? 16'h1111 : 16'h2222);
      prev_c = exp_c;
      prev_d = !exp_c;
    end

    // Reset one cycle after a read grant discards the pending rvalid
    tick();
    set_dbg(1'b0, 1'b0, 10'h000, 16'h0000);
    set_cpu(1'b1, 1'b0, 10'h005, 16'h0000);
    sample();
    check("mr_cpu_gnt", cpu_gnt, 1);
    tick();
    Reset_n = 1'b0;
    set_cpu(1'b0, 1'b0, 10'h000, 16'h0000);
    sample();
    check("mr_rvalid_in_reset", cpu_rvalid, 0);
    tick();
    Reset_n = 1'b1;
    sample();
    check("mr_cpu_rvalid_after", cpu_rvalid, 0);
    check("mr_dbg_rvalid_after", dbg_rvalid, 0);
    check("mr_busy", busy, CLR);
    if (CLR) check("mr_sweep_addr0", ram_addr, 10'h000);
    tick();
    sample();
    check("mr_cpu_rvalid_later", cpu_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
